// File: rtl/multi_nibble_adder.sv
// Nibble-serial adder/subtractor with pushbutton operand entry.
// Buttons are synchronized and debounced; a WIDTH-bit result is produced one nibble per cycle.
module multi_nibble_adder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb1,
  input  logic             pb2,
  input  logic             pb3,
  input  logic             pb4,
  input  logic             sub,
  input  logic [3:0]       Y,
  output logic [WIDTH-1:0] Z,
  output logic             Cout,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned PW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [PW-1:0] LAST     = PW'(NIB - 1);
  localparam logic [7:0]    DEB_LAST = 8'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic [3:0]      armed_q, armed_d;
  logic [3:0]      pulse_q, pulse_d;

  assign raw = {pb4, pb3, pb2, pb1};

  // An armed button counts high cycles and fires; a disarmed one counts low cycles to re-arm.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    pulse_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] == armed_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          cnt_d[i]   = '0;
          armed_d[i] = ~armed_q[i];
          pulse_d[i] = armed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d;
  logic [PW-1:0]    pa_q, pa_d, pb_q, pb_d, idx_q, idx_d;
  logic             carry_q, carry_d, mode_q, mode_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;

  logic [3:0] a_nib, b_nib, b_eff;
  logic [4:0] sum5;
  logic [3:0] low3;

  always_comb begin
    a_nib = a_q[4*idx_q +: 4];
    b_nib = b_q[4*idx_q +: 4];
    b_eff = mode_q ? ~b_nib : b_nib;
    sum5  = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0, carry_q};
    low3  = {1'b0, a_nib[2:0]} + {1'b0, b_eff[2:0]} + {3'b0, carry_q};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    z_d      = z_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    if (pulse_q[3]) begin
      a_d     = '0;
      b_d     = '0;
      pa_d    = '0;
      pb_d    = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pulse_q[0]) begin
            a_d[4*pa_q +: 4] = Y;
            pa_d = (pa_q == LAST) ? '0 : pa_q + 1'b1;
          end
          if (pulse_q[1]) begin
            b_d[4*pb_q +: 4] = Y;
            pb_d = (pb_q == LAST) ? '0 : pb_q + 1'b1;
          end
          if (pulse_q[2]) begin
            state_d = CALC;
            idx_d   = '0;
            carry_d = sub;
            mode_d  = sub;
          end
        end
        CALC: begin
          shadow_d[4*idx_q +: 4] = sum5[3:0];
          carry_d = sum5[4];
          // Result registers load on entry to DONE so they are visible during the DONE cycle.
          if (idx_q == LAST) begin
            state_d = DONE;
            z_d     = shadow_d;
            cout_d  = sum5[4];
            ovf_d   = low3[3] ^ sum5[4];
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      armed_q  <= '1;
      pulse_q  <= '0;
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      shadow_q <= '0;
      z_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      z_q      <= z_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign Z     = z_q;
  assign Cout  = cout_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_multi_nibble_adder.sv
// Bench for multi_nibble_adder: word-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized button activity.
module tb_multi_nibble_adder;

  localparam int unsigned W   = 8;
  localparam int unsigned DEB = 2;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pb1 = 1'b0, pb2 = 1'b0, pb3 = 1'b0, pb4 = 1'b0, sub = 1'b0;
  logic [3:0]   Y = 4'h0;
  logic [W-1:0] Z;
  logic         Cout, ovf, busy, valid;

  multi_nibble_adder #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .pb1(pb1), .pb2(pb2), .pb3(pb3), .pb4(pb4),
    .sub(sub), .Y(Y), .Z(Z), .Cout(Cout), .ovf(ovf), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: button pipeline as level histories and run lengths,
  // arithmetic as whole-word integer math with a fixed result delay.
  logic [3:0]   m_s1 = '0, m_s2 = '0;
  int           m_hi_run[4] = '{0, 0, 0, 0};
  int           m_lo_run[4] = '{0, 0, 0, 0};
  bit           m_arm[4] = '{1, 1, 1, 1};
  bit           m_pulse[4] = '{0, 0, 0, 0};
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_z = '0;
  int           m_pa = 0, m_pb = 0, m_busy_left = 0;
  bit           m_rc = 0, m_ro = 0, m_cout = 0, m_ovf = 0, m_valid = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < 4; i++) begin
      m_hi_run[i] = 0; m_lo_run[i] = 0; m_arm[i] = 1; m_pulse[i] = 0;
    end
    m_a = '0; m_b = '0; m_pa = 0; m_pb = 0; m_busy_left = 0;
    m_z = '0; m_cout = 0; m_ovf = 0; m_valid = 0;
  endtask

  task automatic compute(logic [W-1:0] a, logic [W-1:0] b, bit s);
    longint ua, ub, r;
    ua = longint'(a);
    ub = longint'(b);
    r  = s ? ua - ub : ua + ub;
    m_res = r[W-1:0];
    m_rc  = s ? (ua >= ub) : (r >= (longint'(1) << W));
    if (s) m_ro = (a[W-1] != b[W-1]) && (m_res[W-1] != a[W-1]);
    else   m_ro = (a[W-1] == b[W-1]) && (m_res[W-1] != a[W-1]);
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] raw;
    if (!rst_n) begin
      model_reset();
    end else begin
      raw = {pb4, pb3, pb2, pb1};
      m_valid = 0;
      if (m_pulse[3]) begin
        m_a = '0; m_b = '0; m_pa = 0; m_pb = 0; m_busy_left = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 1) begin
          m_valid = 1; m_z = m_res; m_cout = m_rc; m_ovf = m_ro;
        end
      end else begin
        if (m_pulse[0]) begin m_a[4*m_pa +: 4] = Y; m_pa = (m_pa + 1) % NIB; end
        if (m_pulse[1]) begin m_b[4*m_pb +: 4] = Y; m_pb = (m_pb + 1) % NIB; end
        if (m_pulse[2]) begin compute(m_a, m_b, sub); m_busy_left = NIB + 1; end
      end
      for (int i = 0; i < 4; i++) begin
        m_pulse[i] = 0;
        if (m_arm[i]) begin
          m_hi_run[i] = m_s2[i] ? m_hi_run[i] + 1 : 0;
          if (m_hi_run[i] == DEB) begin
            m_pulse[i] = 1; m_arm[i] = 0; m_lo_run[i] = 0;
          end
        end else begin
          m_lo_run[i] = !m_s2[i] ? m_lo_run[i] + 1 : 0;
          if (m_lo_run[i] == DEB) begin
            m_arm[i] = 1; m_hi_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  always @(posedge clk) begin
    #3;
    check("Z", 32'(Z), 32'(m_z));
    check("Cout", 32'(Cout), 32'(m_cout));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_busy_left > 0));
    check("valid", 32'(valid), 32'(m_valid));
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      1: pb1 = v;
      2: pb2 = v;
      3: pb3 = v;
      4: pb4 = v;
      default: ;
    endcase
  endtask

  task automatic press(int b, logic [3:0] y, int hold);
    @(negedge clk);
    Y = y;
    set_btn(b, 1'b1);
    idle(hold);
    set_btn(b, 1'b0);
    idle(DEB + 6);
  endtask

  // Raw pb3 rises; valid must appear exactly 7 edges later (2 sync + DEB debounce + NIB+1).
  task automatic run_op(string nm, bit s, logic [W-1:0] ez, bit ec, bit eo, int extra);
    int n;
    bit got;
    @(negedge clk);
    sub = s;
    pb3 = 1'b1;
    n = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk);
      #3;
      n++;
      if (valid) got = 1;
      if (n == 1 && extra != 0) begin
        @(negedge clk);
        Y = 4'h9;
        set_btn(extra, 1'b1);
      end
    end
    check({nm, " latency"}, 32'(n), 32'd7);
    check({nm, " Z"}, 32'(Z), 32'(ez));
    check({nm, " Cout"}, 32'(Cout), 32'(ec));
    check({nm, " ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    pb3 = 1'b0;
    set_btn(extra, 1'b0);
    idle(DEB + 6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    idle(3);
    #1;
    check("reset Z", 32'(Z), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 0x7F + 0x01
    press(1, 4'hF, 3); press(1, 4'h7, 3); press(2, 4'h1, 3);
    run_op("add7F01", 1'b0, 8'h80, 1'b0, 1'b1, 0);

    // 0x05 - 0x07, then clear must keep Z
    press(4, 4'h0, 3);
    check("clear keeps Z", 32'(Z), 32'h80);
    press(1, 4'h5, 3); press(2, 4'h7, 3);
    run_op("sub0507", 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    press(4, 4'h0, 3);
    press(1, 4'hF, 3); press(1, 4'hF, 3); press(2, 4'h1, 3);
    run_op("addFF01", 1'b0, 8'h00, 1'b1, 1'b0, 0);

    // glitch is rejected, long hold loads once
    press(4, 4'h0, 3);
    press(1, 4'h3, 1);
    press(1, 4'h5, 10);
    run_op("debounce", 1'b0, 8'h05, 1'b0, 1'b0, 0);

    // abort during CALC
    press(4, 4'h0, 3);
    press(1, 4'h2, 3); press(2, 4'h1, 3);
    @(negedge clk); sub = 1'b0; pb3 = 1'b1;
    @(negedge clk); pb4 = 1'b1;
    idle(4);
    pb3 = 1'b0; pb4 = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #3;
      if (valid) seen = 1;
    end
    check("abort no valid", 32'(seen), 32'd0);
    check("abort keeps Z", 32'(Z), 32'h05);
    check("abort busy", 32'(busy), 32'd0);
    run_op("after abort", 1'b0, 8'h00, 1'b0, 1'b0, 0);

    // pb1 during CALC is ignored
    press(1, 4'h4, 3); press(2, 4'h3, 3);
    run_op("pb1 busy", 1'b0, 8'h07, 1'b0, 1'b0, 1);
    run_op("pb1 busy again", 1'b0, 8'h07, 1'b0, 1'b0, 0);

    // pointer wrap
    press(4, 4'h0, 3);
    press(1, 4'h1, 3); press(1, 4'h2, 3); press(1, 4'h3, 3);
    run_op("wrap", 1'b0, 8'h23, 1'b0, 1'b0, 0);

    // reset mid-CALC
    @(negedge clk); pb3 = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #3;
      if (busy) seen = 1;
    end
    check("busy before reset", 32'(seen), 32'd1);
    @(negedge clk);
    pb3 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset Z", 32'(Z), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset Cout", 32'(Cout), 32'd0);
    check("midreset ovf", 32'(ovf), 32'd0);
    idle(2);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #3;
      if (valid) seen = 1;
    end
    check("no valid after reset", 32'(seen), 32'd0);

    // randomized button activity
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      Y   = 4'($urandom_range(0, 15));
      sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) pb1 = ~pb1;
      if ($urandom_range(0, 5) == 0) pb2 = ~pb2;
      if ($urandom_range(0, 5) == 0) pb3 = ~pb3;
      if (pb4 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0)) pb4 = ~pb4;
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
    end
    @(negedge clk);
    pb1 = 1'b0; pb2 = 1'b0; pb3 = 1'b0; pb4 = 1'b0; rst_n = 1'b1;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
